// File: rtl/x25519_pkg.sv
// Shared types and constants for the X25519 byte-serial front end.
package x25519_pkg;

   typedef logic [255:0] x25519_word_t;

   localparam int X25519_BYTES = 32;

   typedef enum logic [2:0] {
      LOAD_E,
      LOAD_U,
      START,
      WAIT,
      DRAIN
   } frontend_state_t;

   // RFC 7748 scalar clamp and u-coordinate top-bit mask
   localparam logic [7:0] X25519_E_LO_MASK = 8'hF8;
   localparam logic [7:0] X25519_E_HI_AND  = 8'h7F;
   localparam logic [7:0] X25519_E_HI_OR   = 8'h40;
   localparam logic [7:0] X25519_U_HI_MASK = 8'h7F;

   // Clamp one incoming byte according to which word it lands in and where
   function automatic logic [7:0] clamp_byte(input logic is_e, input logic [4:0] idx,
                                             input logic [7:0] b);
      logic [7:0] r;
      r = b;
      if (is_e) begin
         if (idx == 5'd0)
            r = b & X25519_E_LO_MASK;
         else if (idx == 5'd31)
            r = (b & X25519_E_HI_AND) | X25519_E_HI_OR;
      end else if (idx == 5'd31) begin
         r = b & X25519_U_HI_MASK;
      end
      return r;
   endfunction

endpackage

// File: rtl/x25519_byte_shifter.sv
// 256-bit result register: parallel load from the core, byte-wise shift-out
// (LSB byte first) with a byte counter flagging the 32nd byte.
module x25519_byte_shifter
   import x25519_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  x25519_word_t load_data,
   input  logic         shift,
   output logic [7:0]   data,
   output logic         last
);

   x25519_word_t sr;
   logic [4:0]   cnt;

   // Load wins over shift; the counter wraps to 0 after the 32nd shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= load_data;
         cnt <= '0;
      end else if (shift) begin
         sr  <= {8'h00, sr[255:8]};
         cnt <= cnt + 5'd1;
      end
   end

   assign data = sr[7:0];
   assign last = (cnt == 5'd31);

endmodule

// File: rtl/x25519_byte_frontend.sv
// Byte-serial front end for the X25519 main loop: loads 32 scalar bytes and
// 32 u bytes (little-endian), clamps/masks them, pulses the core start, and
// streams the 32-byte result back out.
// Optional: define X25519_ZERO_CHECK_EN to flag an all-zero result.
module x25519_byte_frontend
   import x25519_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic         result_zero,
   output logic         core_en,
   output x25519_word_t core_e,
   output x25519_word_t core_work_in,
   input  logic         core_out_valid,
   input  x25519_word_t core_work_out
);

   frontend_state_t state;
   logic [4:0]      idx;
   logic [7:0]      in_byte;
   logic            in_fire;
   logic            out_fire;
   logic            cap;
   logic            drain_done;

   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   // core strobes outside WAIT (including the START cycle) are dropped here
   assign cap        = (state == WAIT) && core_out_valid;
   assign drain_done = out_fire && out_last;

   // Clamp the byte being written for the word currently loading
   always_comb begin
      in_byte = clamp_byte(state == LOAD_E, idx, in_data);
   end

   // Request sequencer; all handshake/strobe outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD_E;
         idx          <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         core_en      <= 1'b0;
         core_e       <= '0;
         core_work_in <= '0;
      end else begin
         core_en <= 1'b0;
         case (state)
            LOAD_E: if (in_fire) begin
               core_e[{idx, 3'b000} +: 8] <= in_byte;
               idx <= idx + 5'd1;
               if (idx == 5'd31) state <= LOAD_U;
            end
            LOAD_U: if (in_fire) begin
               core_work_in[{idx, 3'b000} +: 8] <= in_byte;
               idx <= idx + 5'd1;
               if (idx == 5'd31) begin
                  state    <= START;
                  core_en  <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            START: state <= WAIT;
            WAIT: if (core_out_valid) begin
               state     <= DRAIN;
               out_valid <= 1'b1;
            end
            DRAIN: if (drain_done) begin
               state     <= LOAD_E;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= LOAD_E;
         endcase
      end
   end

   x25519_byte_shifter u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (cap),
      .load_data (core_work_out),
      .shift     (out_fire),
      .data      (out_data),
      .last      (out_last)
   );

`ifdef X25519_ZERO_CHECK_EN
   // All-zero result flag, captured with the result and held through DRAIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         result_zero <= 1'b0;
      else if (cap)
         result_zero <= (core_work_out == '0);
      else if (drain_done)
         result_zero <= 1'b0;
   end
`else
   assign result_zero = 1'b0;
`endif

endmodule

// File: tb/tb_x25519_byte_frontend.sv
// Scoreboard bench for x25519_byte_frontend with a fixed-latency stub core.
module tb_x25519_byte_frontend;
   import x25519_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_data = 8'h00;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [7:0]   out_data;
   logic         out_last;
   logic         result_zero;
   logic         core_en;
   x25519_word_t core_e, core_work_in;
   logic         core_out_valid;
   x25519_word_t core_work_out;

   always #5 clk = ~clk;

   x25519_byte_frontend dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .result_zero(result_zero),
      .core_en(core_en), .core_e(core_e), .core_work_in(core_work_in),
      .core_out_valid(core_out_valid), .core_work_out(core_work_out)
   );

`ifdef X25519_ZERO_CHECK_EN
   localparam bit ZCHK = 1'b1;
`else
   localparam bit ZCHK = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- stub core ----------------
   localparam int CORE_LAT = 6;
   x25519_word_t resp_word = '0;
   logic stub_v = 1'b0, stub_busy = 1'b0, spur = 1'b0;
   int   stub_cnt = 0;
   assign core_out_valid = stub_v | spur;
   assign core_work_out  = resp_word;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stub_busy <= 1'b0;
         stub_v    <= 1'b0;
         stub_cnt  <= 0;
      end else begin
         stub_v <= 1'b0;
         if (core_en) begin
            stub_busy <= 1'b1;
            stub_cnt  <= CORE_LAT;
         end else if (stub_busy) begin
            if (stub_cnt == 1) begin
               stub_busy <= 1'b0;
               stub_v    <= 1'b1;
            end else begin
               stub_cnt <= stub_cnt - 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       z;
   } ob_t;

   ob_t          oq[$];
   x25519_word_t eq_e[$], eq_u[$];
   x25519_word_t cur_e = '0, cur_u = '0;
   int           en_count = 0;
   logic         prev_en = 1'b0, prev_sv = 1'b0;
   int           gap_pct = 0, stall_pct = 0;

   // output-side backpressure generator
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= stall_pct);
   end

   // monitor: compares DUT outputs against queued expectations
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (out_valid) begin
            if (oq.size() == 0) begin
               total++; bad++;
               $display("FAIL stray_out_valid: actual=1 required=0");
            end else begin
               check("out_data", out_data, oq[0].d);
               check("out_last", out_last, oq[0].l);
               check("result_zero", result_zero, oq[0].z);
               if (out_ready) void'(oq.pop_front());
            end
         end
         if (core_en) begin
            check("core_en_single", prev_en, 1'b0);
            check("in_ready_start", in_ready, 1'b0);
            if (eq_e.size() == 0) begin
               total++; bad++;
               $display("FAIL stray_core_en: actual=1 required=0");
            end else begin
               cur_e = eq_e.pop_front();
               cur_u = eq_u.pop_front();
               check("core_e", core_e, cur_e);
               check("core_work_in", core_work_in, cur_u);
            end
            en_count++;
         end
         if (stub_v) begin
            check("core_e_hold", core_e, cur_e);
            check("core_work_in_hold", core_work_in, cur_u);
            check("out_valid_at_capture", out_valid, 1'b0);
         end
         if (prev_sv) check("out_valid_after_capture", out_valid, 1'b1);
      end
      prev_en = core_en;
      prev_sv = stub_v && rst_n;
   end

   // ---------------- stimulus ----------------
   function automatic x25519_word_t rev(input x25519_word_t w);
      x25519_word_t r;
      for (int k = 0; k < 32; k++) r[k*8 +: 8] = w[(31-k)*8 +: 8];
      return r;
   endfunction

   // 32 bytes LSB first; entered and left at posedge+1
   task automatic send_word(input x25519_word_t w);
      logic hs;
      int   waited;
      for (int k = 0; k < 32; k++) begin
         while (gap_pct != 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = w[k*8 +: 8];
         hs = 1'b0;
         waited = 0;
         while (!hs) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (waited > 3000) begin
               $display("FAIL in_ready_timeout: actual=0 required=1");
               $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
               $fatal(1, "input stalled");
            end
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic run_req(input x25519_word_t e, input x25519_word_t u,
                          input x25519_word_t exp_e, input x25519_word_t exp_u,
                          input x25519_word_t resp, input bit expect_out);
      eq_e.push_back(exp_e);
      eq_u.push_back(exp_u);
      if (expect_out)
         for (int k = 0; k < 32; k++)
            oq.push_back('{d: resp[k*8 +: 8], l: (k == 31), z: ZCHK && (resp == '0)});
      send_word(e);
      resp_word = resp;   // previous request fully drained once e is accepted
      send_word(u);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((oq.size() != 0 || out_valid) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", oq.size(), 0);
   endtask

   x25519_word_t rfc_e, rfc_u, rfc_e_c, rfc_out;

   initial begin
      rfc_e   = rev(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4);
      rfc_e_c = rev(256'ha046e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449a44);
      rfc_u   = rev(256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c);
      rfc_out = rev(256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552);

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_result_zero", result_zero, 1'b0);
      check("rst_core_en", core_en, 1'b0);
      check("rst_core_e", core_e, 256'h0);
      check("rst_core_work_in", core_work_in, 256'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // spurious core strobe while loading: must be ignored
      spur = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      spur = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("spur_out_valid", out_valid, 1'b0);
      check("spur_in_ready", in_ready, 1'b1);

      // RFC 7748 vector 1, no gaps
      run_req(rfc_e, rfc_u, rfc_e_c, rfc_u, rfc_out, 1'b1);

      // clamp boundaries, with gaps and stalls
      gap_pct = 30; stall_pct = 40;
      run_req({8'hFF, {30{8'h11}}, 8'hFF}, {8'hFF, {30{8'h22}}, 8'h05},
              {8'h7F, {30{8'h11}}, 8'hF8}, {8'h7F, {30{8'h22}}, 8'h05},
              {8{32'h0F1E2D3C}}, 1'b1);

      // RFC vector again under gaps and stalls
      run_req(rfc_e, rfc_u, rfc_e_c, rfc_u, rfc_out, 1'b1);
      wait_drain();
      gap_pct = 0; stall_pct = 0;

      // reset during WAIT discards the request
      run_req(rfc_e, rfc_u, rfc_e_c, rfc_u, rfc_out, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("wrst_out_valid", out_valid, 1'b0);
      check("wrst_core_en", core_en, 1'b0);
      check("wrst_in_ready", in_ready, 1'b1);
      check("wrst_core_e", core_e, 256'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (CORE_LAT + 4) @(posedge clk);
      #1;
      check("wrst_no_stale", out_valid, 1'b0);

      run_req({32{8'h5C}}, {32{8'h93}},
              {8'h5C, {30{8'h5C}}, 8'h58}, {8'h13, {31{8'h93}}},
              {4{64'h0123456789ABCDEF}}, 1'b1);

      // all-zero result
      run_req(rfc_e, rfc_u, rfc_e_c, rfc_u, 256'h0, 1'b1);
      wait_drain();
      @(posedge clk);
      #1;
      check("zero_cleared", result_zero, 1'b0);
      check("core_en_count", en_count, 6);
      check("core_en_unseen", eq_e.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/x25519_byte_frontend.md
# x25519_byte_frontend

Byte-serial front end for the X25519 scalar-multiply core (`X25519_MainLoop`). It accepts a 64-byte request over a valid/ready byte stream: 32 scalar bytes, then 32 u-coordinate bytes, both little-endian. It clamps the scalar, masks the u-coordinate, starts the core, and streams the 32-byte result back out over a second valid/ready byte stream. It sits directly upstream and downstream of the core, between the core and the host/bus interface.

## Interface
Parameters: none.
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  reset; asynchronous assert, active-low (already decided)
- `in_valid`  in  1  input byte valid
- `in_ready`  out  1  input byte accepted when `in_valid && in_ready`
- `in_data`  in  8  input byte
- `out_valid`  out  1  result byte valid
- `out_ready`  in  1  downstream accepts result byte
- `out_data`  out  8  result byte, LSB byte first
- `out_last`  out  1  high with the 32nd result byte
- `result_zero`  out  1  all-zero result flag; valid while `out_valid`
- `core_en`  out  1  one-cycle start pulse to the core
- `core_e`  out  256  clamped scalar, byte k at bits [8k+7:8k]
- `core_work_in`  out  256  masked u-coordinate, same byte order
- `core_out_valid`  in  1  core result strobe
- `core_work_out`  in  256  core result

## Operation
- FSM states: LOAD_E, LOAD_U, START, WAIT, DRAIN. The reset state is LOAD_E.
- LOAD_E: `in_ready`=1. Each accepted byte is written to `core_e` byte `idx`, and the 5-bit counter `idx` increments. On the 32nd byte (idx=31), `idx` wraps to 0 and the FSM goes to LOAD_U.
- LOAD_U: same behaviour into `core_work_in`. On the 32nd byte, go to START.
- Clamping is applied as bytes are written:
  - e byte0 &= 0xF8
  - e byte31 = (b & 0x7F) | 0x40
  - u byte31 &= 0x7F
- START: `core_en`=1 for exactly this cycle, then go to WAIT.
- `core_e` and `core_work_in` hold stable from the START cycle until the result has been captured.
- WAIT: on `core_out_valid`, capture `core_work_out` into a 256-bit shift register and go to DRAIN.
- `core_out_valid` in any state other than WAIT is ignored.
- DRAIN: `out_valid`=1 and `out_data`=sr[7:0].
  - Each `out_valid && out_ready` shifts sr right by 8 and increments `idx`.
  - `out_last` = (idx==31).
  - When the last byte is accepted, `idx` is set to 0 and the FSM returns to LOAD_E.
- `in_ready`=0 in START, WAIT and DRAIN. There is no overlap of requests.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `result_zero`=0, `core_en`=0, `core_e`=0, `core_work_in`=0, `idx`=0.
- The last input byte is accepted at cycle N. `core_en` is high at N+1.
- `core_out_valid` is seen at cycle M. `out_valid` rises at M+1.
- Throughput is one byte per cycle on both streams when the handshakes are continuously asserted.
- Backpressure: `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- `in_valid` held low in LOAD states stalls the load with no timeout.
- `rst_n` low in any state (including WAIT) asynchronously forces LOAD_E, drops `core_en` and `out_valid`, and discards partial input. The core is reset by its owner.
- A `core_out_valid` that arrives the same cycle as the START pulse is ignored. Capture happens only in WAIT.

## Configuration
- Macro: `X25519_ZERO_CHECK_EN`.
- Defined: during the WAIT capture, register `result_zero` = (`core_work_out` == 0). It is held through DRAIN and cleared on return to LOAD_E. This supports the RFC 7748 all-zero shared-secret check.
- Undefined: `result_zero` is tied to 0 and the 256-bit compare is not synthesised.

## Structure
- Shared package `x25519_pkg`:
  - `x25519_word_t` (logic[255:0])
  - byte-count constant `X25519_BYTES`=32
  - enum `frontend_state_t`
  - clamp masks `X25519_E_LO_MASK`=8'hF8, `X25519_E_HI_AND`=8'h7F, `X25519_E_HI_OR`=8'h40, `X25519_U_HI_MASK`=8'h7F
- One sub-module, `x25519_byte_shifter`: the 256-bit parallel-load / shift-out register with byte counter used in DRAIN.

## Test plan
- RFC 7748 vector 1:
  - stimulus: scalar bytes a5 46 e3 … 9a c4, then u bytes e6 db 68 … 1c 4c
  - required: `core_e` byte0=0xA0 and byte31=0x44, `core_work_in` byte31=0x4C, exactly one `core_en` pulse
  - with the core attached, the output is c3 da 55 … 85 52 with `out_last` on byte 31
- u byte31=0xFF -> `core_work_in` byte31=0x7F. Scalar byte0=0xFF -> 0xF8.
- Random `in_valid` gaps and random `out_ready` deasserts -> identical bytes to the gap-free run, and `out_data` stable during stalls.
- Assert `rst_n` low during WAIT, then run a full request -> no stale output, and the new result is correct.
- Stubbed core returns all zero:
  - with `X25519_ZERO_CHECK_EN`, `result_zero`=1 for all 32 bytes
  - without it, `result_zero`=0
- Spurious `core_out_valid` in LOAD_E -> no `out_valid`, and the FSM stays in LOAD_E.
